// File: rtl/pc_step_ctrl.sv
// picoMIPS sequencing controller: owns the PC increment enable, stalls on wait/halt,
// debounces SW8 and runs a press/release handshake that strobes the SW[7:0] capture once.
module pc_step_ctrl #(
    parameter int DB_CYCLES = 50000,
    parameter int DBW       = 16,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sw8_raw,
    input  logic          wait_req,
    input  logic          halt_req,
    output logic          pc_en,
    output logic          sw_latch_en,
    output logic [2:0]    ctrl_state,
    output logic          sw8_db,
    output logic [CW-1:0] hs_count
);

    typedef enum logic [2:0] {
        ST_RUN          = 3'b000,
        ST_WAIT_PRESS   = 3'b001,
        ST_WAIT_RELEASE = 3'b010,
        ST_RESUME       = 3'b011,
        ST_HALT         = 3'b100
    } state_t;

    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [DBW-1:0]  db_cnt_q, db_cnt_d;
    logic            sw8_db_q, sw8_db_d;
    logic [CW-1:0]   hs_count_q, hs_count_d;
    logic            hs_done;

    // Two-flop synchroniser; sync2_q is the only view of the switch inside this block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw8_raw;
            sync2_q <= sync1_q;
        end
    end

    // The counter only runs while the synchronised level disagrees with the debounced one.
    always_comb begin
        db_cnt_d = '0;
        sw8_db_d = sw8_db_q;
        if (sync2_q != sw8_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                sw8_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign hs_done    = (state_q == ST_WAIT_RELEASE) && !sw8_db_q;
    assign hs_count_d = (hs_done && (hs_count_q != '1)) ? hs_count_q + 1'b1 : hs_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            db_cnt_q   <= '0;
            sw8_db_q   <= 1'b0;
            hs_count_q <= '0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            sw8_db_q   <= sw8_db_d;
            hs_count_q <= hs_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (wait_req) begin
                    state_d = ST_WAIT_PRESS;
                end
            end
            ST_WAIT_PRESS: begin
                if (sw8_db_q) state_d = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (!sw8_db_q) state_d = ST_RESUME;
            end
            ST_RESUME: state_d = ST_RUN;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_RUN;
        endcase
    end

    // RESUME steps the PC past the wait instruction regardless of the decoder.
    always_comb begin
        pc_en       = 1'b0;
        sw_latch_en = 1'b0;
        case (state_q)
            ST_RUN:        pc_en = ~wait_req & ~halt_req;
            ST_WAIT_PRESS: sw_latch_en = sw8_db_q;
            ST_RESUME:     pc_en = 1'b1;
            default: begin
                pc_en       = 1'b0;
                sw_latch_en = 1'b0;
            end
        endcase
    end

    assign ctrl_state = state_q;
    assign sw8_db     = sw8_db_q;
    assign hs_count   = hs_count_q;

endmodule
